regfile_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the 8-entry x 16-bit single-port register file. It accepts read/write commands from two independent masters (A, B) and grants them round-robin. It drives the register file's write-data, address and mutually exclusive write/read enables for exactly one cycle per command. For reads, it captures the registered read data and returns it to the winning master with a one-cycle valid pulse.

---
 rtl/regfile_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// Round-robin two-master sequencer for a single-port 8x16 register file.
// One command in flight: IDLE arbitrates, ISSUE drives the file, CAPTURE returns read data.

module regfile_arbiter_port #(
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cap,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= cap;
      if (cap) rdata <= rf_rd_data;
    end
  end
endmodule

module regfile_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              busy,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_wr_en,
  output logic              rf_rd_en,
  input  logic [DATA_W-1:0] rf_rd_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t state, state_d;
  logic   ptr, ptr_d;   // 0 = A has priority on contention
  logic   win, win_d;   // 0 = A, 1 = B
  logic   issue;
  logic   sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      ptr   <= 1'b0;
      win   <= 1'b0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      win   <= win_d;
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    win_d   = win;
    issue   = 1'b0;
    case (state)
      IDLE: if (req_a || req_b) begin
        win_d   = (req_a && req_b) ? ptr : req_b;
        ptr_d   = ~win_d;
        issue   = 1'b1;
        state_d = ISSUE;
      end
      // rf_wr_en still carries the issued command's direction here
      ISSUE:   state_d = rf_wr_en ? IDLE : CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sel_we    = win_d ? we_b    : we_a;
  assign sel_addr  = win_d ? addr_b  : addr_a;
  assign sel_wdata = win_d ? wdata_b : wdata_a;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      busy       <= 1'b0;
      rf_addr    <= '0;
      rf_wr_data <= '0;
    end else begin
      gnt_a    <= issue & ~win_d;
      gnt_b    <= issue &  win_d;
      rf_wr_en <= issue &  sel_we;
      rf_rd_en <= issue & ~sel_we;
      busy     <= (state_d != IDLE);
      if (issue) begin
        rf_addr    <= sel_addr;
        rf_wr_data <= sel_wdata;
      end
    end
  end

  logic [1:0]             rvalid_v;
  logic [1:0][DATA_W-1:0] rdata_v;

  for (genvar g = 0; g < 2; g++) begin : g_port
    regfile_arbiter_port #(.DATA_W(DATA_W)) u_port (
      .CLK        (CLK),
      .RST        (RST),
      .cap        ((state == CAPTURE) && (win == g[0])),
      .rf_rd_data (rf_rd_data),
      .rvalid     (rvalid_v[g]),
      .rdata      (rdata_v[g])
    );
  end

  assign rvalid_a = rvalid_v[0];
  assign rvalid_b = rvalid_v[1];
  assign rdata_a  = rdata_v[0];
  assign rdata_b  = rdata_v[1];
endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural registered-read register file.

module tb_regfile_arbiter;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        req_a = 0, req_b = 0, we_a = 0, we_b = 0;
  logic [2:0]  addr_a = 0, addr_b = 0;
  logic [15:0] wdata_a = 0, wdata_b = 0;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b, busy, rf_wr_en, rf_rd_en;
  logic [15:0] rdata_a, rdata_b, rf_wr_data, rf_rd_data;
  logic [2:0]  rf_addr;
  logic        pre = 1'b0;
  logic [15:0] mem [8];

  int n_vec = 0;
  int n_err = 0;

  regfile_arbiter dut (
    .CLK(CLK), .RST(RST),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy),
    .rf_wr_data(rf_wr_data), .rf_addr(rf_addr),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_rd_data(rf_rd_data)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (pre)
      for (int i = 0; i < 8; i++) mem[i] <= 16'h0100 + 16'(i);
    else if (rf_wr_en)
      mem[rf_addr] <= rf_wr_data;
    if (rf_rd_en) rf_rd_data <= mem[rf_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (rf_wr_en && rf_rd_en) chk("rf_en_excl", 1, 0);
    if (gnt_a && gnt_b)       chk("gnt_excl", 1, 0);
  end

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [63:0] outs();
    return {gnt_a, gnt_b, rvalid_a, rvalid_b, busy, rf_wr_en, rf_rd_en,
            rf_addr, rf_wr_data, rdata_a, rdata_b};
  endfunction

  task automatic do_reset;
    RST = 1'b0;
    req_a = 0; req_b = 0; we_a = 0; we_b = 0;
    step; step;
    RST = 1'b1;
  endtask

  int ia, ib, k, ra, rb;
  logic [15:0] exp_a, exp_b;

  initial begin
    // reset state
    do_reset;
    chk("reset_outs", outs(), 0);
    pre = 1'b1; step; pre = 1'b0;

    // A writes 0xBEEF @5 then reads it back
    req_a = 1; we_a = 1; addr_a = 5; wdata_a = 16'hBEEF;
    step;
    chk("wr_gnt_a", {gnt_a, gnt_b, rf_wr_en, rf_rd_en, busy}, 5'b10101);
    chk("wr_addr_data", {rf_addr, rf_wr_data}, {3'd5, 16'hBEEF});
    req_a = 0;
    step;
    chk("wr_done", {gnt_a, rf_wr_en, busy}, 3'b000);
    req_a = 1; we_a = 0;
    step;
    chk("rd_gnt_a", {gnt_a, rf_wr_en, rf_rd_en, busy}, 4'b1011);
    req_a = 0;
    step;
    chk("rd_capture", {gnt_a, rf_rd_en, busy, rvalid_a}, 4'b0010);
    step;
    chk("rd_rvalid", {rvalid_a, rvalid_b, busy}, 3'b100);
    chk("rd_data_a", rdata_a, 16'hBEEF);
    step;
    chk("rd_rvalid_pulse", {rvalid_a, rdata_a}, {1'b0, 16'hBEEF});

    // simultaneous writes after reset: A first, then B; B's data survives
    do_reset;
    req_a = 1; we_a = 1; addr_a = 2; wdata_a = 16'h1111;
    req_b = 1; we_b = 1; addr_b = 2; wdata_b = 16'h2222;
    step;
    chk("cont_first", {gnt_a, gnt_b, rf_wr_data}, {2'b10, 16'h1111});
    req_a = 0;
    step;
    chk("cont_issue_end", {gnt_a, gnt_b}, 2'b00);
    step;
    chk("cont_second", {gnt_a, gnt_b, rf_wr_data}, {2'b01, 16'h2222});
    req_b = 0;
    step;
    req_a = 1; we_a = 0; addr_a = 2;
    step; req_a = 0;
    step; step;
    chk("cont_readback", {rvalid_a, rdata_a}, {1'b1, 16'h2222});

    // sustained read contention, addresses preloaded with 0x0100+n
    do_reset;
    pre = 1'b1; step; pre = 1'b0;
    ia = 0; ib = 0; k = 0; ra = 0; rb = 0; exp_a = 0; exp_b = 0;
    req_a = 1; we_a = 0; addr_a = 0;
    req_b = 1; we_b = 0; addr_b = 5;
    for (int cyc = 0; cyc < 60 && (ra < 6 || rb < 6); cyc++) begin
      step;
      if (gnt_a || gnt_b) begin
        chk("rr_order", {gnt_a, gnt_b}, (k % 2 == 0) ? 2'b10 : 2'b01);
        k++;
      end
      if (gnt_a) begin
        ia++;
        if (ia == 6) req_a = 0; else addr_a = 3'(ia);
      end
      if (gnt_b) begin
        ib++;
        if (ib == 6) req_b = 0; else addr_b = 3'(5 - ib);
      end
      if (rvalid_a) begin exp_a = 16'h0100 + 16'(ra);     ra++; end
      if (rvalid_b) begin exp_b = 16'h0100 + 16'(5 - rb); rb++; end
      chk("rr_rdata_a", rdata_a, exp_a);
      chk("rr_rdata_b", rdata_b, exp_b);
    end
    chk("rr_count_a", ra, 6);
    chk("rr_count_b", rb, 6);
    chk("rr_grants", k, 12);
    req_a = 0; req_b = 0;

    // request raised while A's read is in ISSUE
    do_reset;
    chk("busy_pre", busy, 0);
    req_a = 1; we_a = 0; addr_a = 3;
    step;
    chk("busy_gnt_a", {gnt_a, busy}, 2'b11);
    req_a = 0; req_b = 1; we_b = 0; addr_b = 1;
    step;
    chk("busy_no_gnt_issue", {gnt_b, busy}, 2'b01);
    step;
    chk("busy_no_gnt_capture", {gnt_b, busy, rvalid_a, rdata_a}, {3'b001, 16'h0103});
    step;
    chk("busy_late_gnt_b", {gnt_b, busy}, 2'b11);
    req_b = 0;
    step; step;
    chk("busy_rvalid_b", {rvalid_b, rdata_b}, {1'b1, 16'h0101});

    // reset asserted during CAPTURE
    step;
    req_a = 1; we_a = 0; addr_a = 4;
    step; req_a = 0;
    step;
    RST = 1'b0;
    #1;
    chk("rst_mid_outs", outs(), 0);
    step;
    chk("rst_no_rvalid", {rvalid_a, rvalid_b}, 2'b00);
    RST = 1'b1;
    req_b = 1; we_b = 0; addr_b = 0;
    step;
    chk("rst_gnt_b", {gnt_a, gnt_b}, 2'b01);
    req_b = 0;
    step; step;
    chk("rst_rvalid_b", {rvalid_b, rdata_b}, {1'b1, 16'h0100});
    req_a = 1; we_a = 1; addr_a = 6; wdata_a = 16'hAAAA;
    req_b = 1; we_b = 1; addr_b = 7; wdata_b = 16'hBBBB;
    step;
    chk("rst_cont_a", {gnt_a, gnt_b}, 2'b10);
    req_a = 0;
    step; step;
    chk("rst_cont_b", {gnt_a, gnt_b}, 2'b01);
    req_b = 0;
    step; step;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
